// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control_seq
//  Description : ALU control for the multi-cycle RV32IM core. Decodes
//                alu_op/f3/f7 into an ALU function code plus an illegal flag,
//                and sequences iterative M-extension ops through an
//                md_start / stall / op_done handshake.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                op_valid           instruction needs ALU control this cycle
//                alu_op, f3, f7     decode inputs
//                alu_function       ALU function code (15 = mul/div result)
//                illegal            unsupported encoding while op_valid
//                md_start, md_op    launch pulse and latched f3 for mul/div
//                stall, op_done     datapath hold and result-valid pulse
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control_seq #(
    parameter int FUNC_W      = 4,
    parameter int ENABLE_M    = 1,
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        f3,
    input  logic [6:0]        f7,
    output logic [FUNC_W-1:0] alu_function,
    output logic              illegal,
    output logic              md_start,
    output logic [2:0]        md_op,
    output logic              stall,
    output logic              op_done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0] c_f_add   = 4'd0;
    localparam logic [3:0] c_f_sub   = 4'd1;
    localparam logic [3:0] c_f_and   = 4'd2;
    localparam logic [3:0] c_f_or    = 4'd3;
    localparam logic [3:0] c_f_xor   = 4'd4;
    localparam logic [3:0] c_f_slt   = 4'd5;
    localparam logic [3:0] c_f_sltu  = 4'd6;
    localparam logic [3:0] c_f_sll   = 4'd7;
    localparam logic [3:0] c_f_srl   = 4'd8;
    localparam logic [3:0] c_f_sra   = 4'd9;
    localparam logic [3:0] c_f_mdres = 4'd15;

    // Counter is loaded with latency-1 so that RUN lasts exactly LATENCY cycles.
    localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(DIV_LATENCY - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_md_op;

    logic [3:0]       w_dec_func;
    logic             w_dec_bad;
    logic             w_dec_m;

    logic [3:0]       w_func;
    logic             w_illegal;
    logic             w_md_start;
    logic             w_stall;
    logic             w_op_done;

    // ------------------------------------------------------------------------
    // Instruction decode (pure combinational, independent of state)
    // ------------------------------------------------------------------------
    always_comb begin
        w_dec_func = c_f_add;
        w_dec_bad  = 1'b0;
        w_dec_m    = 1'b0;
        case (alu_op)
            2'b00: w_dec_func = c_f_add;
            2'b01: begin
                case (f3)
                    3'b000, 3'b001: w_dec_func = c_f_sub;
                    3'b100, 3'b101: w_dec_func = c_f_slt;
                    3'b110, 3'b111: w_dec_func = c_f_sltu;
                    default:        w_dec_bad  = 1'b1;
                endcase
            end
            2'b10: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  w_dec_func = c_f_add;
                        3'b001:  w_dec_func = c_f_sll;
                        3'b010:  w_dec_func = c_f_slt;
                        3'b011:  w_dec_func = c_f_sltu;
                        3'b100:  w_dec_func = c_f_xor;
                        3'b101:  w_dec_func = c_f_srl;
                        3'b110:  w_dec_func = c_f_or;
                        default: w_dec_func = c_f_and;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'b000:  w_dec_func = c_f_sub;
                        3'b101:  w_dec_func = c_f_sra;
                        default: w_dec_bad  = 1'b1;
                    endcase
                end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
                    w_dec_m    = 1'b1;
                    w_dec_func = c_f_mdres;
                end else begin
                    w_dec_bad = 1'b1;
                end
            end
            default: begin
                // I-type: f7 is imm[11:5] and only qualifies the shift forms.
                case (f3)
                    3'b000: w_dec_func = c_f_add;
                    3'b001: begin
                        if (f7 == 7'b0000000) w_dec_func = c_f_sll;
                        else                  w_dec_bad  = 1'b1;
                    end
                    3'b010: w_dec_func = c_f_slt;
                    3'b011: w_dec_func = c_f_sltu;
                    3'b100: w_dec_func = c_f_xor;
                    3'b101: begin
                        if (f7 == 7'b0000000)      w_dec_func = c_f_srl;
                        else if (f7 == 7'b0100000) w_dec_func = c_f_sra;
                        else                       w_dec_bad  = 1'b1;
                    end
                    3'b110:  w_dec_func = c_f_or;
                    default: w_dec_func = c_f_and;
                endcase
            end
        endcase
        if (w_dec_bad) begin
            w_dec_func = c_f_add;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_func      = w_dec_func;
        w_illegal   = 1'b0;
        w_md_start  = 1'b0;
        w_stall     = 1'b0;
        w_op_done   = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_illegal = op_valid & w_dec_bad;
                if (op_valid && w_dec_m) begin
                    w_md_start  = 1'b1;
                    w_stall     = 1'b1;
                    w_cnt_nxt   = f3[2] ? c_div_cnt : c_mul_cnt;
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                w_stall = 1'b1;
                w_func  = c_f_mdres;
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_st_done: begin
                // New ops are deliberately not accepted here; they wait one cycle.
                w_op_done   = 1'b1;
                w_func      = c_f_mdres;
                w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (rst) begin
            w_func     = c_f_add;
            w_illegal  = 1'b0;
            w_md_start = 1'b0;
            w_stall    = 1'b0;
            w_op_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_md_op <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_md_start) begin
                r_md_op <= f3;
            end
        end
    end

    assign alu_function = FUNC_W'(w_func);
    assign illegal      = w_illegal;
    assign md_start     = w_md_start;
    assign md_op        = r_md_op;
    assign stall        = w_stall;
    assign op_done      = w_op_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control_seq
//  Description : Self-checking bench for alu_control_seq: decode vector table,
//                encoding sweep, multi-cycle handshake sequences and a
//                randomized run against a cycle-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_control_seq;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk;
    logic       rst;
    logic       op_valid;
    logic       nm_valid;
    logic [1:0] alu_op;
    logic [2:0] f3;
    logic [6:0] f7;

    logic [3:0] alu_function, nm_alu_function;
    logic       illegal, nm_illegal;
    logic       md_start, nm_md_start;
    logic [2:0] md_op, nm_md_op;
    logic       stall, nm_stall;
    logic       op_done, nm_op_done;

    int checks   = 0;
    int failures = 0;

    alu_control_seq #(
        .FUNC_W(4), .ENABLE_M(1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .alu_op(alu_op), .f3(f3), .f7(f7),
        .alu_function(alu_function), .illegal(illegal), .md_start(md_start),
        .md_op(md_op), .stall(stall), .op_done(op_done)
    );

    alu_control_seq #(
        .FUNC_W(4), .ENABLE_M(0), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6)
    ) dut_nm (
        .clk(clk), .rst(rst), .op_valid(nm_valid), .alu_op(alu_op), .f3(f3), .f7(f7),
        .alu_function(nm_alu_function), .illegal(nm_illegal), .md_start(nm_md_start),
        .md_op(nm_md_op), .stall(nm_stall), .op_done(nm_op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode tables indexed by f3 (-1 marks an illegal encoding).
    int base_tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int br_tab[8]   = '{1, 1, -1, -1, 5, 5, 6, 6};

    function automatic void ref_decode(input logic [1:0] op, input logic [2:0] ff3,
                                       input logic [6:0] ff7, input bit en_m,
                                       output int func, output bit bad, output bit is_m);
        func = 0; bad = 0; is_m = 0;
        if (op == 2'b00) func = 0;
        else if (op == 2'b01) func = br_tab[ff3];
        else if (op == 2'b10) begin
            if (ff7 == 7'h00) func = base_tab[ff3];
            else if (ff7 == 7'h20) func = (ff3 == 3'd0) ? 1 : (ff3 == 3'd5) ? 9 : -1;
            else if (ff7 == 7'h01 && en_m) begin is_m = 1; func = 15; end
            else func = -1;
        end else begin
            if (ff3 == 3'd1) func = (ff7 == 7'h00) ? 7 : -1;
            else if (ff3 == 3'd5) func = (ff7 == 7'h00) ? 8 : (ff7 == 7'h20) ? 9 : -1;
            else func = base_tab[ff3];
        end
        if (func < 0) begin bad = 1; func = 0; end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic settle(); #2; endtask
    task automatic adv(); @(posedge clk); #2; endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [2:0] ff3,
                          input logic [6:0] ff7);
        op_valid = v; alu_op = op; f3 = ff3; f7 = ff7;
    endtask

    // Called in the first cycle after an accept; returns cycles until op_done.
    task automatic wait_done(output int n);
        bit got;
        got = 0; n = 0;
        op_valid = 1'b0;
        while (!got && n < 100) begin
            settle();
            n++;
            if (op_done) got = 1;
            adv();
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] ff3;
        logic [6:0] ff7;
        logic       v;
        int         func;
        int         ill;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int n, fn, bad_stall, bad_start, ef;
        bit eb, em;
        int done_at, exp_md_op, lat;
        bit exp_start;

        vecs[0]  = '{2'b10, 3'b000, 7'h20, 1'b1, 1, 0};
        vecs[1]  = '{2'b10, 3'b000, 7'h00, 1'b1, 0, 0};
        vecs[2]  = '{2'b10, 3'b001, 7'h00, 1'b1, 7, 0};
        vecs[3]  = '{2'b10, 3'b101, 7'h20, 1'b1, 9, 0};
        vecs[4]  = '{2'b10, 3'b010, 7'h20, 1'b1, 0, 1};
        vecs[5]  = '{2'b10, 3'b111, 7'h00, 1'b1, 2, 0};
        vecs[6]  = '{2'b10, 3'b100, 7'h04, 1'b1, 0, 1};
        vecs[7]  = '{2'b11, 3'b101, 7'h03, 1'b1, 0, 1};
        vecs[8]  = '{2'b11, 3'b101, 7'h20, 1'b1, 9, 0};
        vecs[9]  = '{2'b11, 3'b001, 7'h20, 1'b1, 0, 1};
        vecs[10] = '{2'b11, 3'b011, 7'h7f, 1'b1, 6, 0};
        vecs[11] = '{2'b01, 3'b010, 7'h00, 1'b1, 0, 1};
        vecs[12] = '{2'b01, 3'b101, 7'h00, 1'b1, 5, 0};
        vecs[13] = '{2'b01, 3'b111, 7'h00, 1'b1, 6, 0};
        vecs[14] = '{2'b01, 3'b001, 7'h00, 1'b1, 1, 0};
        vecs[15] = '{2'b00, 3'b111, 7'h7f, 1'b1, 0, 0};
        vecs[16] = '{2'b10, 3'b110, 7'h00, 1'b0, 3, 0};
        vecs[17] = '{2'b01, 3'b011, 7'h00, 1'b0, 0, 0};
        vecs[18] = '{2'b11, 3'b101, 7'h03, 1'b0, 0, 0};

        // ---------------- reset ----------------
        rst = 1'b1; nm_valid = 1'b0;
        set_in(1'b1, 2'b10, 3'b000, 7'h20);
        adv(); settle();
        chk("rst_func", alu_function, 0);
        chk("rst_stall", stall, 0);
        chk("rst_illegal", illegal, 0);
        adv();
        rst = 1'b0;
        settle();
        chk("post_rst_md_op", md_op, 0);
        chk("post_rst_sub_func", alu_function, 1);
        chk("post_rst_stall", stall, 0);

        // ---------------- decode vector table ----------------
        foreach (vecs[i]) begin
            set_in(vecs[i].v, vecs[i].op, vecs[i].ff3, vecs[i].ff7);
            nm_valid = vecs[i].v;
            settle();
            chk($sformatf("vec%0d_func", i), alu_function, vecs[i].func);
            chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
            chk($sformatf("vec%0d_stall", i), stall, 0);
            chk($sformatf("vec%0d_nm_func", i), nm_alu_function, vecs[i].func);
            adv();
        end

        // ---------------- encoding sweep ----------------
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 8; k++) begin
                for (int j = 0; j < 4; j++) begin
                    logic [6:0] fv;
                    fv = (j == 0) ? 7'h00 : (j == 1) ? 7'h20 : (j == 2) ? 7'h01 : 7'h03;
                    ref_decode(op[1:0], k[2:0], fv, 1'b1, ef, eb, em);
                    set_in(!em, op[1:0], k[2:0], fv);
                    nm_valid = 1'b1;
                    settle();
                    if (!em) chk("sweep_func", alu_function, ef);
                    chk("sweep_illegal", illegal, int'(!em && eb));
                    ref_decode(op[1:0], k[2:0], fv, 1'b0, ef, eb, em);
                    chk("sweep_nm_func", nm_alu_function, ef);
                    chk("sweep_nm_illegal", nm_illegal, int'(eb));
                    adv();
                end
            end
        end
        nm_valid = 1'b0;

        // ---------------- MUL latency, no accept in DONE ----------------
        set_in(1'b1, 2'b10, 3'b000, 7'h01);
        settle();
        chk("mul_start", md_start, 1);
        chk("mul_stall_t0", stall, 1);
        adv();
        for (int t = 1; t <= 4; t++) begin
            settle();
            chk("mul_run_stall", stall, 1);
            chk("mul_run_start", md_start, 0);
            chk("mul_run_done", op_done, 0);
            chk("mul_run_func", alu_function, 15);
            adv();
        end
        settle();
        chk("mul_t5_done", op_done, 1);
        chk("mul_t5_stall", stall, 0);
        chk("mul_t5_start", md_start, 0);
        chk("mul_md_op", md_op, 0);
        adv();
        settle();
        chk("mul_reaccept_start", md_start, 1);
        adv();
        wait_done(n);
        chk("mul2_latency", n, 5);

        // ---------------- DIVU with input noise in RUN ----------------
        set_in(1'b1, 2'b10, 3'b101, 7'h01);
        settle();
        chk("divu_start", md_start, 1);
        adv();
        n = 0; fn = 0; bad_stall = 0; bad_start = 0;
        while (fn == 0 && n < 100) begin
            set_in(1'($urandom), 2'($urandom), 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h01 : 7'($urandom));
            settle();
            n++;
            if (op_done) begin
                fn = 1;
                chk("divu_done_stall", stall, 0);
                chk("divu_done_start", md_start, 0);
            end else begin
                if (!stall || illegal) bad_stall++;
                if (md_start) bad_start++;
            end
            adv();
        end
        op_valid = 1'b0;
        chk("divu_latency", n, DIV_LAT + 1);
        chk("divu_run_stall_errs", bad_stall, 0);
        chk("divu_run_start_errs", bad_start, 0);
        chk("divu_md_op", md_op, 5);
        adv();

        // ---------------- reset abort in RUN ----------------
        set_in(1'b1, 2'b10, 3'b011, 7'h01);
        settle();
        chk("abort_start", md_start, 1);
        adv(); adv();
        rst = 1'b1;
        settle();
        chk("abort_rst_stall", stall, 0);
        chk("abort_rst_func", alu_function, 0);
        adv();
        rst = 1'b0; op_valid = 1'b0;
        settle();
        chk("abort_stall", stall, 0);
        chk("abort_md_op", md_op, 0);
        fn = 0;
        for (int t = 0; t < 40; t++) begin
            settle();
            if (op_done || stall) fn++;
            adv();
        end
        chk("abort_no_done", fn, 0);
        set_in(1'b1, 2'b10, 3'b000, 7'h01);
        settle();
        chk("abort_mul_start", md_start, 1);
        adv();
        wait_done(n);
        chk("abort_mul_latency", n, MUL_LAT + 1);

        // ---------------- ENABLE_M=0 ----------------
        op_valid = 1'b0; nm_valid = 1'b1;
        alu_op = 2'b10; f3 = 3'b000; f7 = 7'h01;
        settle();
        chk("nm_mul_illegal", nm_illegal, 1);
        chk("nm_mul_start", nm_md_start, 0);
        chk("nm_mul_stall", nm_stall, 0);
        adv();
        alu_op = 2'b01; f3 = 3'b010; f7 = 7'h00;
        settle();
        chk("nm_br_illegal", nm_illegal, 1);
        adv();
        nm_valid = 1'b0;

        // ---------------- randomized run vs. reference model ----------------
        done_at = -1; exp_md_op = 0;
        for (int c = 0; c < 1500; c++) begin
            logic [6:0] fv;
            int sel;
            sel = $urandom_range(0, 3);
            fv = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            set_in($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), fv);
            settle();
            if (rst) begin
                chk("rnd_rst_out", {md_start, stall, op_done, illegal}, 0);
                chk("rnd_rst_func", alu_function, 0);
                done_at = -1; exp_md_op = 0;
            end else if (done_at >= 0 && c < done_at) begin
                chk("rnd_run_out", {md_start, stall, op_done, illegal}, 4'b0100);
                chk("rnd_run_func", alu_function, 15);
                chk("rnd_run_md_op", md_op, exp_md_op);
            end else if (c == done_at) begin
                chk("rnd_done_out", {md_start, stall, op_done, illegal}, 4'b0010);
                chk("rnd_done_func", alu_function, 15);
                done_at = -1;
            end else begin
                ref_decode(alu_op, f3, f7, 1'b1, ef, eb, em);
                exp_start = op_valid && em;
                chk("rnd_idle_out", {md_start, stall, op_done, illegal},
                    {exp_start, exp_start, 1'b0, op_valid && eb});
                if (!em) chk("rnd_idle_func", alu_function, ef);
                chk("rnd_idle_md_op", md_op, exp_md_op);
                if (exp_start) begin
                    lat = f3[2] ? DIV_LAT : MUL_LAT;
                    done_at = c + lat + 1;
                    exp_md_op = f3;
                end
            end
            adv();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
